// File: rtl/mc_seq_controller_if.sv
// Bundle of every signal between the multicycle sequencing controller and the
// surrounding datapath (IR/ALU on the input side, PC, register file and memory
// strobes on the output side).
//
// Handshake: imem_req / dmem_rd / dmem_wr behave as "valid", imem_ack / dmem_ack
// as "ready". A request is raised in IF/MEM and held unchanged until the cycle in
// which its ack is seen; the transfer happens in exactly that cycle (req && ack),
// and the matching load/write enable (ir_we, pc_we) fires in that same cycle.
//
// Modports:
//   master - the controller: reads opcode/zero/acks, drives state and strobes
//   slave  - the datapath side: drives opcode/zero/acks, reads state and strobes
interface mc_seq_controller_if #(
    parameter int RETIRE_W = 32
);
    logic [5:0]          opcode;
    logic                zero;
    logic                imem_ack;
    logic                dmem_ack;
    logic [3:0]          state;
    logic                imem_req;
    logic                ir_we;
    logic                dmem_rd;
    logic                dmem_wr;
    logic                reg_we;
    logic                wb_sel;
    logic                pc_we;
    logic [1:0]          pc_src;
    logic                halted;
    logic                bus_err;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  opcode, zero, imem_ack, dmem_ack,
        output state, imem_req, ir_we, dmem_rd, dmem_wr, reg_we, wb_sel,
               pc_we, pc_src, halted, bus_err, retired
    );

    modport slave (
        output opcode, zero, imem_ack, dmem_ack,
        input  state, imem_req, ir_we, dmem_rd, dmem_wr, reg_we, wb_sel,
               pc_we, pc_src, halted, bus_err, retired
    );
endinterface

// File: rtl/mc_seq_controller.sv
// Sequencing controller for the multicycle CPU. Steps each instruction through
// IF/ID/EXE/MEM/WB, issues the per-cycle control strobes, waits on the memory
// handshakes with a bounded timeout, counts retired instructions and traps on
// HALT or a memory timeout.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset; also forces all strobes low
//   bus  - mc_seq_controller_if.master (opcode/zero/acks in; state, strobes,
//          halted, bus_err, retired out)
module mc_seq_controller #(
    parameter int RETIRE_W    = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mc_seq_controller_if.master  bus
);
    typedef enum logic [3:0] {
        S_IF   = 4'b0000,
        S_ID   = 4'b0001,
        S_CEXE = 4'b0010,
        S_MEM  = 4'b0011,
        S_CWB  = 4'b0100,
        S_BEXE = 4'b0101,
        S_AEXE = 4'b0110,
        S_AWB  = 4'b0111,
        S_HALT = 4'b1000
    } state_t;

    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Counter only ever needs to reach MEM_TIMEOUT-1 before leaving the state.
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                bus_err_q;
    logic [RETIRE_W-1:0] retired_q;

    logic       waiting;
    logic       timeout_hit;
    logic       is_jump;
    logic       retire;
    logic       imem_req, ir_we, dmem_rd, dmem_wr, reg_we, wb_sel, pc_we;
    logic [1:0] pc_src;

    // A wait cycle is an IF or MEM cycle whose ack is missing.
    assign waiting     = ((state_q == S_IF) && !bus.imem_ack) ||
                         ((state_q == S_MEM) && !bus.dmem_ack);
    // An ack on the final count is not a wait cycle, so it wins over the timeout.
    assign timeout_hit = (MEM_TIMEOUT > 0) && waiting && (wait_cnt == WAIT_LAST);
    assign is_jump     = (bus.opcode[5:3] == 3'b111) && (bus.opcode != OP_HALT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter, sticky bus error and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + RETIRE_W'(1);
            end
            // Any state change clears the count, which covers entry to IF and MEM.
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if ((MEM_TIMEOUT > 0) && waiting) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (bus.imem_ack) begin
                    state_d = S_ID;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                end
            end
            S_ID: begin
                case (bus.opcode[5:3])
                    3'b110:  state_d = (bus.opcode == OP_BEQ) ? S_BEXE : S_CEXE;
                    3'b111:  state_d = (bus.opcode == OP_HALT) ? S_HALT : S_IF;
                    default: state_d = S_AEXE;
                endcase
            end
            S_AEXE: state_d = S_AWB;
            S_AWB:  state_d = S_IF;
            S_BEXE: state_d = S_IF;
            S_CEXE: state_d = S_MEM;
            S_MEM: begin
                if (bus.dmem_ack) begin
                    state_d = (bus.opcode == OP_LW) ? S_CWB : S_IF;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                end
            end
            S_CWB:  state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Output decode.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_rd  = 1'b0;
        dmem_wr  = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 2'b00;
        retire   = 1'b0;
        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                ir_we    = bus.imem_ack;
            end
            S_ID: begin
                if (is_jump) begin
                    pc_we  = 1'b1;
                    pc_src = 2'b11;
                    retire = 1'b1;
                end
            end
            S_AWB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            S_BEXE: begin
                pc_we  = 1'b1;
                pc_src = bus.zero ? 2'b01 : 2'b00;
                retire = 1'b1;
            end
            S_MEM: begin
                if (bus.opcode == OP_LW) begin
                    dmem_rd = 1'b1;
                end else begin
                    dmem_wr = 1'b1;
                    pc_we   = bus.dmem_ack;
                    retire  = bus.dmem_ack;
                end
            end
            S_CWB: begin
                reg_we = 1'b1;
                wb_sel = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons the instruction outright; a timeout cycle issues nothing.
        if (rst || timeout_hit) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            dmem_rd  = 1'b0;
            dmem_wr  = 1'b0;
            reg_we   = 1'b0;
            wb_sel   = 1'b0;
            pc_we    = 1'b0;
            pc_src   = 2'b00;
            retire   = 1'b0;
        end
    end

    assign bus.state    = state_q;
    assign bus.imem_req = imem_req;
    assign bus.ir_we    = ir_we;
    assign bus.dmem_rd  = dmem_rd;
    assign bus.dmem_wr  = dmem_wr;
    assign bus.reg_we   = reg_we;
    assign bus.wb_sel   = wb_sel;
    assign bus.pc_we    = pc_we;
    assign bus.pc_src   = pc_src;
    assign bus.halted   = (state_q == S_HALT);
    assign bus.bus_err  = bus_err_q;
    assign bus.retired  = retired_q;
endmodule

// File: tb/tb_mc_seq_controller.sv
// Self-checking bench for mc_seq_controller (RETIRE_W=4, MEM_TIMEOUT=4).
// Each cycle's expected output vector is
//   {state, imem_req, ir_we, dmem_rd, dmem_wr, reg_we, wb_sel, pc_we, pc_src,
//    halted, bus_err, retired}
// and is queued together with that cycle's ack inputs.
module tb_mc_seq_controller;
    localparam int W = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [W-1:0] exp_q[$];
    logic [1:0]   stim_q[$];
    logic [3:0]   exp_ret = 4'd0;
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_vec;

    mc_seq_controller_if #(.RETIRE_W(4)) bus ();

    mc_seq_controller #(.RETIRE_W(4), .MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Clock / reset
    always #5 clk = ~clk;

    assign obs_vec = {bus.state, bus.imem_req, bus.ir_we, bus.dmem_rd, bus.dmem_wr,
                      bus.reg_we, bus.wb_sel, bus.pc_we, bus.pc_src,
                      bus.halted, bus.bus_err, bus.retired};

    // Driver: queue one cycle of acks and the outputs required in that cycle.
    // Strobe order: {imem_req, ir_we, dmem_rd, dmem_wr, reg_we, wb_sel, pc_we}.
    task automatic push(input logic [3:0] st, input logic [6:0] sb, input logic [1:0] src,
                        input logic h, input logic be, input logic i_ack, input logic d_ack);
        exp_q.push_back({st, sb, src, h, be, exp_ret});
        stim_q.push_back({i_ack, d_ack});
    endtask

    task automatic push_rtype();
        push(4'h0, 7'b1100000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'h1, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'h6, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'h7, 7'b0000101, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_ret = exp_ret + 4'd1;
    endtask

    task automatic push_jump();
        push(4'h0, 7'b1100000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'h1, 7'b0000001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ret = exp_ret + 4'd1;
    endtask

    task automatic push_store(input int waits);
        push(4'h0, 7'b1100000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'h1, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'h2, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < waits; i++) push(4'h3, 7'b0001000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'h3, 7'b0001001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_ret = exp_ret + 4'd1;
    endtask

    task automatic test_reset();
        bus.opcode = 6'd0; bus.zero = 1'b0; bus.imem_ack = 1'b1; bus.dmem_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (obs_vec !== {4'h0, 7'b0, 2'b00, 1'b0, 1'b0, 4'h0}) begin
            fails++;
            $display("FAIL reset: got %h exp %h", obs_vec, {4'h0, 7'b0, 2'b00, 1'b0, 1'b0, 4'h0});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ret = 4'd0;
    endtask

    task automatic test_rtype();
        bus.opcode = 6'b000000;
        push_rtype();
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL rtype: got %h exp %h", obs_vec, exp_v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch(input logic z);
        bus.opcode = 6'b110100;
        bus.zero   = z;
        push(4'h0, 7'b1100000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'h1, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'h5, 7'b0000001, z ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ret = exp_ret + 4'd1;
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL branch z=%0b: got %h exp %h", z, obs_vec, exp_v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump();
        bus.opcode = 6'b111000;
        push_jump();
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL jump: got %h exp %h", obs_vec, exp_v); end
            @(posedge clk); #1;
        end
    endtask

    // Load with dmem_ack three cycles late; the ack lands on the final count.
    task automatic test_load_store();
        bus.opcode = 6'b110001;
        push(4'h0, 7'b1100000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'h1, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'h2, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(4'h3, 7'b0010000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'h3, 7'b0010000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        push(4'h4, 7'b0000111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_ret = exp_ret + 4'd1;
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL load: got %h exp %h", obs_vec, exp_v); end
            @(posedge clk); #1;
        end
        bus.opcode = 6'b110000;
        push_store(1);
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL store: got %h exp %h", obs_vec, exp_v); end
            @(posedge clk); #1;
        end
    endtask

    // imem_ack arrives in the fourth IF cycle: a normal fetch, no error.
    task automatic test_imem_late();
        bus.opcode = 6'b111010;
        for (int i = 0; i < 3; i++) push(4'h0, 7'b1000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push_jump();
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL imem_late: got %h exp %h", obs_vec, exp_v); end
            @(posedge clk); #1;
        end
    endtask

    // Enough back-to-back jumps to carry the 4-bit counter through 15 -> 0.
    task automatic test_wrap();
        bus.opcode = 6'b111001;
        for (int i = 0; i < 17; i++) push_jump();
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL wrap: got %h exp %h", obs_vec, exp_v); end
            @(posedge clk); #1;
        end
    endtask

    // Async reset pulse mid-cycle; checked before any clock edge.
    task automatic reset_pulse(input logic i_ack, input logic d_ack);
        bus.imem_ack = i_ack;
        bus.dmem_ack = d_ack;
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (obs_vec !== {4'h0, 7'b0, 2'b00, 1'b0, 1'b0, 4'h0}) begin
            fails++;
            $display("FAIL async_reset: got %h exp %h", obs_vec, {4'h0, 7'b0, 2'b00, 1'b0, 1'b0, 4'h0});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.dmem_ack = 1'b0;
        exp_ret = 4'd0;
    endtask

    task automatic test_timeout();
        bus.opcode = 6'b000000;
        for (int i = 0; i < 3; i++) push(4'h0, 7'b1000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'h0, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            push(4'h8, 7'b0, 2'b00, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL timeout: got %h exp %h", obs_vec, exp_v); end
            @(posedge clk); #1;
        end
        reset_pulse(1'b1, 1'b1);
    endtask

    task automatic test_halt();
        bus.opcode = 6'b111111;
        push(4'h0, 7'b1100000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'h1, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            push(4'h8, 7'b0, 2'b00, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL halt: got %h exp %h", obs_vec, exp_v); end
            @(posedge clk); #1;
        end
        reset_pulse(1'b0, 1'b0);
    endtask

    // Reset lands in MEM of a store while dmem_ack is high: no PC write, no retire.
    task automatic test_reset_mid_store();
        bus.opcode = 6'b110000;
        push(4'h0, 7'b1100000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        push(4'h1, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'h2, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'h3, 7'b0001000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL reset_mid_store: got %h exp %h", obs_vec, exp_v); end
            @(posedge clk); #1;
        end
        reset_pulse(1'b0, 1'b1);
    endtask

    // Restarted fetch followed by mixed instructions with no idle cycles.
    task automatic test_back_to_back();
        bus.opcode = 6'b000000;
        push_rtype();
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL back_to_back rtype: got %h exp %h", obs_vec, exp_v); end
            @(posedge clk); #1;
        end
        bus.opcode = 6'b110000;
        push_store(0);
        while (exp_q.size() > 0) begin
            {bus.imem_ack, bus.dmem_ack} = stim_q.pop_front();
            @(negedge clk);
            exp_v = exp_q.pop_front();
            tests++;
            if (obs_vec !== exp_v) begin fails++; $display("FAIL back_to_back store: got %h exp %h", obs_vec, exp_v); end
            @(posedge clk); #1;
        end
        test_jump();
        @(negedge clk);
        tests++;
        if (bus.retired !== 4'd3) begin
            fails++;
            $display("FAIL back_to_back retired: got %0d exp %0d", bus.retired, 3);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jump();
        test_load_store();
        test_imem_late();
        test_wrap();
        test_timeout();
        test_halt();
        test_reset_mid_store();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
